// File: rtl/sram_ctrl_pkg.sv
// Shared types and derived-constant helpers for the parametrised SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int beats_f(input int data_w);
        return data_w / 16;
    endfunction

    function automatic int t_f(input int wait_cyc);
        return wait_cyc + 2;
    endfunction

    // A single-beat word still carries one beat bit in the SRAM address.
    function automatic int bw_f(input int beats);
        return (beats > 2) ? $clog2(beats) : 1;
    endfunction

    function automatic int lsb_f(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/sram_ctrl_param_if.sv
// Word-wide single-request memory port between a requester and the SRAM controller.
interface sram_ctrl_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_W-1:0]     adr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     rd_data;
    logic                  ready;

    modport master (output wr_en, rd_en, adr, wr_data, be, input rd_data, ready);
    modport slave  (input wr_en, rd_en, adr, wr_data, be, output rd_data, ready);
endinterface

// File: rtl/sram_beat_counter.sv
// Cycle-within-beat and beat-within-word counter; held at zero while not running.
module sram_beat_counter #(
    parameter int T     = 2,
    parameter int BEATS = 2,
    parameter int CW    = 1,
    parameter int BW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [CW-1:0] cnt,
    output logic [BW-1:0] beat,
    output logic          last_cyc,
    output logic          last_beat
);

    assign last_cyc  = (cnt == CW'(T - 1));
    assign last_beat = (beat == BW'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            beat <= '0;
        end else if (!run) begin
            cnt  <= '0;
            beat <= '0;
        end else if (last_cyc) begin
            cnt  <= '0;
            beat <= last_beat ? '0 : beat + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_ctrl_param.sv
// Splits each requester word access into 16-bit SRAM beats with programmable wait cycles.
//   state | meaning
//   IDLE  | waiting for rd_en/wr_en; request latched on exit
//   BEAT  | driving one 16-bit SRAM cycle of T clocks per beat
//   DONE  | access complete, ready high for one cycle
module sram_ctrl_param
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SRAM_AW  = 18,
    parameter int WAIT_CYC = 0
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_param_if.slave   bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int BEATS = beats_f(DATA_W);
    localparam int T     = t_f(WAIT_CYC);
    localparam int BW    = bw_f(BEATS);
    localparam int LSB   = lsb_f(DATA_W);
    localparam int WA_W  = ADDR_W - LSB;
    localparam int CW    = $clog2(T);

    state_t              state, state_nx;
    logic                op_wr;
    logic [WA_W-1:0]     word_addr;
    logic [DATA_W-1:0]   wr_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   cap, cap_nx, rd_q;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       beat;
    logic                last_cyc, last_beat;
    logic                req, start, rd_cap;
    logic                be_lo, be_hi, dq_oe;
    logic [15:0]         wr_slice;

    assign req    = bus.rd_en | bus.wr_en;
    assign start  = (state == IDLE) && req;
    assign rd_cap = (state == BEAT) && last_cyc && !op_wr;

    sram_beat_counter #(.T(T), .BEATS(BEATS), .CW(CW), .BW(BW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .run       (state == BEAT),
        .cnt       (cnt),
        .beat      (beat),
        .last_cyc  (last_cyc),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = BEAT;
            BEAT:    if (last_cyc && last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write wins when both requests are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr     <= 1'b0;
            word_addr <= '0;
            wr_q      <= '0;
            be_q      <= '0;
        end else if (start) begin
            op_wr     <= bus.wr_en;
            word_addr <= bus.adr[ADDR_W-1:LSB];
            wr_q      <= bus.wr_data;
            be_q      <= bus.be;
        end
    end

    // Last beat is merged combinationally so rd_data is complete in DONE.
    always_comb begin
        cap_nx = cap;
        cap_nx[{beat, 4'b0000} +: 16] = SRAM_DQ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap  <= '0;
            rd_q <= '0;
        end else if (rd_cap) begin
            cap <= cap_nx;
            if (last_beat) rd_q <= cap_nx;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.ready   = (state == DONE) || ((state == IDLE) && !req);

    assign be_lo    = be_q[{beat, 1'b0}];
    assign be_hi    = be_q[{beat, 1'b1}];
    assign wr_slice = wr_q[{beat, 4'b0000} +: 16];

    always_comb begin
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        if (state == BEAT) begin
            SRAM_CE_N = 1'b0;
            SRAM_ADDR = SRAM_AW'({word_addr, beat});
            if (op_wr) begin
                dq_oe     = 1'b1;
                SRAM_LB_N = ~be_lo;
                SRAM_UB_N = ~be_hi;
                SRAM_WE_N = last_cyc | ~(be_lo | be_hi);
            end else begin
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ = dq_oe ? wr_slice : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Directed bench for sram_ctrl_param: three configurations, each with a small SRAM model.
module tb_sram_ctrl_param;
    import sram_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sram_ctrl_param_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
    sram_ctrl_param_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
    sram_ctrl_param_if #(.DATA_W(64), .ADDR_W(32)) b2 ();

    wire  [15:0] dq0, dq1, dq2;
    logic [17:0] ad0, ad1, ad2;
    logic ub_n0, lb_n0, we_n0, ce_n0, oe_n0;
    logic ub_n1, lb_n1, we_n1, ce_n1, oe_n1;
    logic ub_n2, lb_n2, we_n2, ce_n2, oe_n2;
    logic [15:0] m0 [0:63];
    logic [15:0] m1 [0:63];
    logic [15:0] m2 [0:63];

    sram_ctrl_param #(.DATA_W(32), .ADDR_W(32), .SRAM_AW(18), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .SRAM_DQ(dq0), .SRAM_ADDR(ad0),
        .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0), .SRAM_WE_N(we_n0), .SRAM_CE_N(ce_n0), .SRAM_OE_N(oe_n0));
    sram_ctrl_param #(.DATA_W(32), .ADDR_W(32), .SRAM_AW(18), .WAIT_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .SRAM_DQ(dq1), .SRAM_ADDR(ad1),
        .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1), .SRAM_WE_N(we_n1), .SRAM_CE_N(ce_n1), .SRAM_OE_N(oe_n1));
    sram_ctrl_param #(.DATA_W(64), .ADDR_W(32), .SRAM_AW(18), .WAIT_CYC(1)) dut2 (
        .clk(clk), .rst(rst), .bus(b2), .SRAM_DQ(dq2), .SRAM_ADDR(ad2),
        .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2), .SRAM_WE_N(we_n2), .SRAM_CE_N(ce_n2), .SRAM_OE_N(oe_n2));

    // SRAM models: drive on read, park the bus at 0 while deselected, else float.
    assign dq0 = (!ce_n0 && !oe_n0 && we_n0) ? m0[ad0[5:0]] : (ce_n0 ? 16'h0000 : 16'hzzzz);
    assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? m1[ad1[5:0]] : (ce_n1 ? 16'h0000 : 16'hzzzz);
    assign dq2 = (!ce_n2 && !oe_n2 && we_n2) ? m2[ad2[5:0]] : (ce_n2 ? 16'h0000 : 16'hzzzz);

    always @(posedge clk) begin
        if (!ce_n1 && !we_n1) begin
            if (!lb_n1) m1[ad1[5:0]][7:0]  = dq1[7:0];
            if (!ub_n1) m1[ad1[5:0]][15:8] = dq1[15:8];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int  n;
        bit  flag;
        rst = 1'b0;
        b0.wr_en = 0; b0.rd_en = 0; b0.adr = '0; b0.wr_data = '0; b0.be = '0;
        b1.wr_en = 0; b1.rd_en = 0; b1.adr = '0; b1.wr_data = '0; b1.be = '0;
        b2.wr_en = 0; b2.rd_en = 0; b2.adr = '0; b2.wr_data = '0; b2.be = '0;
        for (int i = 0; i < 64; i++) begin
            m0[i] = 16'h0000; m1[i] = 16'h0000; m2[i] = 16'h0000;
        end
        m0[8] = 16'hBEEF; m0[9] = 16'hDEAD;
        m1[2] = 16'hAAAA; m1[5] = 16'hCAFE;
        m2[12] = 16'h1111; m2[13] = 16'h2222; m2[14] = 16'h3333; m2[15] = 16'h4444;
        #2 rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ready", b0.ready, 1'b1);
        chk("rst_rd_data", b0.rd_data, 32'h0);
        chk("rst_ctl_n", {ub_n0, lb_n0, we_n0, ce_n0, oe_n0}, 5'h1f);
        chk("rst_addr_dq", {ad0, dq0}, 34'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {b1.ready, b2.ready}, 2'b11);
        chk("idle_rd_data64", b2.rd_data, 64'h0);

        // 32-bit read, no wait cycles
        b0.adr = 32'h0000_0010;
        b0.rd_en = 1'b1;
        #1 chk("rd_req_ready", b0.ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("rd_beat", {b0.ready, ad0, ce_n0, oe_n0, we_n0}, {1'b0, 18'(8 + (i - 1) / 2), 3'b001});
        end
        @(negedge clk);
        chk("rd_done_ready", b0.ready, 1'b1);
        chk("rd_data", b0.rd_data, 32'hDEADBEEF);
        b0.rd_en = 1'b0;
        @(negedge clk);
        chk("rd_after_idle", {b0.ready, ce_n0, b0.rd_data}, {2'b11, 32'hDEADBEEF});

        // 32-bit write, 2 wait cycles, be=1101
        b1.adr = 32'h4; b1.wr_data = 32'h1234_5678; b1.be = 4'b1101; b1.wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 4)
                chk("wr_beat0", {b1.ready, ad1, dq1, ub_n1, lb_n1, we_n1, ce_n1, oe_n1},
                    {1'b0, 18'd2, 16'h5678, 1'b1, 1'b0, (i == 4), 1'b0, 1'b1});
            else
                chk("wr_beat1", {b1.ready, ad1, dq1, ub_n1, lb_n1, we_n1, ce_n1, oe_n1},
                    {1'b0, 18'd3, 16'h1234, 1'b0, 1'b0, (i == 8), 1'b0, 1'b1});
        end
        @(negedge clk);
        chk("wr_ready_c9", b1.ready, 1'b1);
        b1.wr_en = 1'b0;
        chk("wr_mem2", m1[2], 16'hAA78);
        chk("wr_mem3", m1[3], 16'h1234);
        @(negedge clk);

        // Write with upper halfword fully disabled
        b1.adr = 32'h8; b1.wr_data = 32'h9999_1111; b1.be = 4'b0011; b1.wr_en = 1'b1;
        n = 0; flag = 1'b0;
        do begin
            @(negedge clk); n++;
            if (n >= 5 && n <= 8 && we_n1 !== 1'b1) flag = 1'b1;
        end while (b1.ready !== 1'b1 && n < 40);
        chk("be0011_latency", n, 9);
        chk("be0011_we_low_beat1", flag, 1'b0);
        chk("be0011_mem", {m1[5], m1[4]}, 32'hCAFE_1111);
        b1.wr_en = 1'b0;
        @(negedge clk);

        // Read to give rd_data a known value
        b1.adr = 32'h4; b1.rd_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (b1.ready !== 1'b1 && n < 40);
        chk("rd1_data", b1.rd_data, 32'h1234_AA78);
        b1.rd_en = 1'b0;
        @(negedge clk);

        // rd_en and wr_en together: write, rd_data untouched
        b1.adr = 32'hC; b1.wr_data = 32'h5555_6666; b1.be = 4'b1111;
        b1.wr_en = 1'b1; b1.rd_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (b1.ready !== 1'b1 && n < 40);
        chk("both_latency", n, 9);
        chk("both_rd_data_held", b1.rd_data, 32'h1234_AA78);
        chk("both_mem", {m1[7], m1[6]}, 32'h5555_6666);
        b1.wr_en = 1'b0;
        @(negedge clk);
        chk("b2b_idle_gap", {b1.ready, ce_n1}, 2'b01);
        @(negedge clk);
        chk("b2b_start", {ad1, ce_n1, oe_n1, we_n1}, {18'd6, 3'b001});
        n = 1;
        do begin @(negedge clk); n++; end while (b1.ready !== 1'b1 && n < 40);
        chk("b2b_latency", n, 9);
        chk("b2b_rd_data", b1.rd_data, 32'h5555_6666);
        b1.rd_en = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write, during beat 1
        b1.adr = 32'h10; b1.wr_data = 32'hABCD_0123; b1.be = 4'b1111; b1.wr_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_wr_beat1", {ad1, dq1, we_n1, ce_n1}, {18'd9, 16'hABCD, 2'b00});
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl", {we_n1, ce_n1, oe_n1, ub_n1, lb_n1}, 5'h1f);
        chk("mid_rst_bus", {ad1, dq1}, 34'h0);
        chk("mid_rst_rd_data", {b1.rd_data, b0.rd_data}, 64'h0);
        b1.wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {b1.ready, we_n1, ce_n1}, 3'b111);

        // 64-bit read, 1 wait cycle
        b2.adr = 32'h18; b2.rd_en = 1'b1;
        n = 0; flag = 1'b0;
        do begin
            @(negedge clk); n++;
            if (n <= 12 && (ad2 !== 18'(12 + (n - 1) / 3) || oe_n2 !== 1'b0)) flag = 1'b1;
        end while (b2.ready !== 1'b1 && n < 40);
        chk("rd64_latency", n, 13);
        chk("rd64_addr_seq", flag, 1'b0);
        chk("rd64_data", b2.rd_data, 64'h4444_3333_2222_1111);
        b2.rd_en = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
